issue_ctrl: RTL

// Parametrised issue-stage controller for the Tomasulo core. Decodes op/func into ALU control and

---
 rtl/issue_ctrl.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/issue_ctrl.sv
// Issue-stage controller for the Tomasulo core.
// Decodes op/func into ALU control and a target reservation-station class,
// keeps one occupancy counter per RS class in place of external full flags,
// applies back-pressure to fetch, and drains every station after a HALT.
//
// Encodings, taken to match the rest of the core:
//   opcodes : R-format 6'h00, ADDI 6'h08, ORI 6'h0D, LW 6'h23, HALT 6'h3F
//   funcs   : ADD 6'h20, SUB 6'h22, AND 6'h24, MULU 6'h19, DIVU 6'h1B
//   ALU     : Add 0, Sub 1, And 2, Or 3
//   reg_dst : FromRd 1, FromRt 0
//   vk_src  : FromRtData 1, FromImmd 0
//   queue_op: opLoad 1, opStore 0
// The signal called "release" in the core is i_release here, because
// "release" is a reserved word.
module issue_ctrl #(
    parameter  int NUM_CLASS = 3,
    parameter  int RS_DEPTH  = 3,
    localparam int CNT_W     = $clog2(RS_DEPTH + 1),
    localparam int CLS_W     = $clog2(NUM_CLASS)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_in_valid,
    output logic                       o_in_ready,
    input  logic [5:0]                 i_op,
    input  logic [5:0]                 i_func,
    input  logic [NUM_CLASS-1:0]       i_release,
    output logic                       o_issue_valid,
    output logic [NUM_CLASS-1:0]       o_issue_en,
    output logic [1:0]                 o_alu_op,
    output logic                       o_reg_dst,
    output logic                       o_vk_src,
    output logic                       o_queue_op,
    output logic [NUM_CLASS*CNT_W-1:0] o_occupancy,
    output logic [NUM_CLASS-1:0]       o_full,
    output logic                       o_halted,
    output logic                       o_release_err
);
    localparam logic [5:0] OP_R    = 6'h00;
    localparam logic [5:0] OP_ADDI = 6'h08;
    localparam logic [5:0] OP_ORI  = 6'h0D;
    localparam logic [5:0] OP_LW   = 6'h23;
    localparam logic [5:0] OP_HALT = 6'h3F;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_MULU = 6'h19;
    localparam logic [5:0] FN_DIVU = 6'h1B;

    typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_HALTED} state_t;

    state_t               r_state;
    state_t               w_state_next;
    logic [CLS_W-1:0]     w_class;
    logic [1:0]           w_alu_op;
    logic                 w_is_r;
    logic                 w_is_halt;
    logic                 w_accept;
    logic                 w_issue;
    logic [NUM_CLASS-1:0] w_nonzero;
    logic [NUM_CLASS-1:0] w_rel_bad;
    logic [NUM_CLASS-1:0] w_class_oh;

    assign w_is_r    = (i_op == OP_R);
    assign w_is_halt = (i_op == OP_HALT);
    assign w_accept  = i_in_valid && o_in_ready;
    assign w_issue   = w_accept && !w_is_halt;
    assign o_halted  = (r_state == ST_HALTED);

    // Decode: RS class from func, ALU control from op/func
    always_comb begin
        w_class  = '0;
        w_alu_op = 2'd1;
        if (i_func == FN_MULU)
            w_class = CLS_W'(1);
        else if (i_func == FN_DIVU)
            w_class = CLS_W'(2);
        if (w_is_r) begin
            if (i_func == FN_ADD || i_func == FN_MULU)
                w_alu_op = 2'd0;
            else if (i_func == FN_SUB)
                w_alu_op = 2'd1;
            else if (i_func == FN_AND)
                w_alu_op = 2'd2;
            else
                w_alu_op = 2'd3;
        end else if (i_op == OP_ADDI) begin
            w_alu_op = 2'd0;
        end else if (i_op == OP_ORI) begin
            w_alu_op = 2'd3;
        end
    end

    // One occupancy counter per class; a release at zero is dropped and flagged
    generate
        for (genvar gi = 0; gi < NUM_CLASS; gi++) begin : g_cls
            logic [CNT_W-1:0] r_cnt;
            logic             w_inc;
            logic             w_dec;

            assign w_class_oh[gi] = (w_class == CLS_W'(gi));
            assign w_inc          = w_issue && w_class_oh[gi];
            assign w_nonzero[gi]  = (r_cnt != '0);
            assign w_dec          = i_release[gi] && w_nonzero[gi];
            assign w_rel_bad[gi]  = i_release[gi] && !w_nonzero[gi];
            assign o_full[gi]     = (r_cnt == CNT_W'(RS_DEPTH));
            assign o_occupancy[gi*CNT_W +: CNT_W] = r_cnt;

            // Count issues in, releases out; simultaneous pair cancels
            always_ff @(posedge clk) begin
                if (rst)
                    r_cnt <= '0;
                else if (w_inc && !w_dec)
                    r_cnt <= r_cnt + CNT_W'(1);
                else if (!w_inc && w_dec)
                    r_cnt <= r_cnt - CNT_W'(1);
            end
        end
    endgenerate

    // Run/drain/halt state register
    always_ff @(posedge clk) begin
        if (rst)
            r_state <= ST_RUN;
        else
            r_state <= w_state_next;
    end

    // Next state and fetch back-pressure; release never reaches in_ready combinationally
    always_comb begin
        w_state_next = r_state;
        o_in_ready   = 1'b0;
        case (r_state)
            ST_RUN: begin
                o_in_ready = w_is_halt ? 1'b1 : !o_full[w_class];
                if (i_in_valid && w_is_halt)
                    w_state_next = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (w_nonzero == '0)
                    w_state_next = ST_HALTED;
            end
            default: w_state_next = ST_HALTED;
        endcase
    end

    // Sticky flag for releases that arrive on an empty class
    always_ff @(posedge clk) begin
        if (rst)
            o_release_err <= 1'b0;
        else if (w_rel_bad != '0)
            o_release_err <= 1'b1;
    end

    // Registered issue interface: pulse valid/enable, hold decode fields between issues
    always_ff @(posedge clk) begin
        if (rst) begin
            o_issue_valid <= 1'b0;
            o_issue_en    <= '0;
            o_alu_op      <= 2'd0;
            o_reg_dst     <= 1'b0;
            o_vk_src      <= 1'b0;
            o_queue_op    <= 1'b0;
        end else begin
            o_issue_valid <= w_issue;
            o_issue_en    <= w_issue ? w_class_oh : '0;
            if (w_issue) begin
                o_alu_op   <= w_alu_op;
                o_reg_dst  <= w_is_r;
                o_vk_src   <= w_is_r;
                o_queue_op <= (i_op == OP_LW);
            end
        end
    end
endmodule
